// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the write-back queue.
//   WORD_SIZE_DEF / ADDRESS_SIZE_DEF : default data and register-address widths
//   ZERO_REG                         : hard-wired zero register address
//   wb_entry_t                       : one queued write {dest, data}
package wb_write_queue_pkg;

    localparam int WORD_SIZE_DEF    = 32;
    localparam int ADDRESS_SIZE_DEF = 4;

    localparam logic [ADDRESS_SIZE_DEF-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDRESS_SIZE_DEF-1:0] dest;
        logic [WORD_SIZE_DEF-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle of the write-back queue.
//   requests : mem_valid/mem_dest/mem_data/mem_ready, alu_valid/alu_dest/alu_data/alu_ready
//   hazards  : src1/src2 in, hazard1/hazard2 out
//   drain    : writeBackEn, Dest_wb, Result_WB, count
// Handshake: a request transfers on a rising clk edge where its valid and
// ready are both high. Ready depends only on the queue occupancy (and, for
// the ALU port, on mem_valid), never on the port's own valid.
interface wb_write_queue_if
    import wb_write_queue_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int DEPTH        = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    mem_valid;
    logic [ADDRESS_SIZE-1:0] mem_dest;
    logic [WORD_SIZE-1:0]    mem_data;
    logic                    mem_ready;
    logic                    alu_valid;
    logic [ADDRESS_SIZE-1:0] alu_dest;
    logic [WORD_SIZE-1:0]    alu_data;
    logic                    alu_ready;
    logic [ADDRESS_SIZE-1:0] src1;
    logic [ADDRESS_SIZE-1:0] src2;
    logic                    hazard1;
    logic                    hazard2;
    logic                    writeBackEn;
    logic [ADDRESS_SIZE-1:0] Dest_wb;
    logic [WORD_SIZE-1:0]    Result_WB;
    logic [CNT_W-1:0]        count;

    modport master (
        output mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data, src1, src2,
        input  mem_ready, alu_ready, hazard1, hazard2, writeBackEn, Dest_wb, Result_WB, count
    );

    modport slave (
        input  mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data, src1, src2,
        output mem_ready, alu_ready, hazard1, hazard2, writeBackEn, Dest_wb, Result_WB, count
    );

endinterface

// File: rtl/wb_write_queue_fifo.sv
// wb_fifo: in-order DEPTH-entry FIFO with two push ports and one pop port.
//   push0_* : first entry written this cycle (older)
//   push1_* : second entry, only meaningful together with push0_en
//   pop     : remove the head (ignored when empty)
//   head_dest/head_data : head entry, forced to 0 when empty
//   count   : occupancy
//   entry_dest/entry_valid : per-slot dest and occupancy flag for compares
// The caller guarantees pushes never exceed the free space.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0_en,
    input  logic [ADDR_W-1:0]            push0_dest,
    input  logic [DATA_W-1:0]            push0_data,
    input  logic                         push1_en,
    input  logic [ADDR_W-1:0]            push1_dest,
    input  logic [DATA_W-1:0]            push1_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_dest,
    output logic [DATA_W-1:0]            head_data,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_dest,
    output logic [DEPTH-1:0]             entry_valid
);
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic                         pop_eff;

    assign pop_eff = pop && (count_q != '0);

    always_comb begin
        dest_d   = dest_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push0_en) begin
            dest_d[wr_ptr_d] = push0_dest;
            data_d[wr_ptr_d] = push0_data;
            wr_ptr_d         = wr_ptr_d + 1'b1;
        end
        // Second slot follows the first, so ordering within a cycle is kept.
        if (push1_en) begin
            dest_d[wr_ptr_d] = push1_dest;
            data_d[wr_ptr_d] = push1_data;
            wr_ptr_d         = wr_ptr_d + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push0_en) + CW'(push1_en) - CW'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

    assign count      = count_q;
    assign head_dest  = (count_q != '0) ? dest_q[rd_ptr_q] : '0;
    assign head_data  = (count_q != '0) ? data_q[rd_ptr_q] : '0;
    assign entry_dest = dest_q;

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] offs;
        assign offs           = PW'(i) - rd_ptr_q;
        assign entry_valid[i] = CW'(offs) < count_q;
    end

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: producer side of the register file's write-back port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request ports (mem, alu), hazard compare, drain outputs, count
// Requests are filtered for dest 0, ordered mem-before-alu, buffered, and
// drained one per cycle. The head is popped on every edge while non-empty,
// so occupancy in steady state stays at most DEPTH-1.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int DEPTH        = 4
) (
    input logic              clk,
    input logic              rst,
    wb_write_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

    logic [CW-1:0]                      count;
    logic [DEPTH-1:0][ADDRESS_SIZE-1:0] entry_dest;
    logic [DEPTH-1:0]                   entry_valid;
    logic                               mem_acc, alu_acc;
    logic                               mem_store, alu_store;
    logic                               push0_en, push1_en;
    wb_entry_t                          mem_req, alu_req, push0, push1;
    logic                               hit1, hit2;

    // Ready looks at the registered count only; a same-cycle pop frees nothing.
    assign bus.mem_ready = !rst && (count < DEPTH_C);
    assign bus.alu_ready = !rst && (bus.mem_valid ? (count <= DEPTH_M2) : (count < DEPTH_C));

    assign mem_acc   = bus.mem_valid && bus.mem_ready;
    assign alu_acc   = bus.alu_valid && bus.alu_ready;
    assign mem_store = mem_acc && (bus.mem_dest != ZERO_REG);
    assign alu_store = alu_acc && (bus.alu_dest != ZERO_REG);

    assign mem_req = '{dest: bus.mem_dest, data: bus.mem_data};
    assign alu_req = '{dest: bus.alu_dest, data: bus.alu_data};

    // Compact the stored requests onto the two FIFO push slots, mem first.
    always_comb begin
        push0_en = mem_store || alu_store;
        push0    = mem_store ? mem_req : alu_req;
        push1_en = mem_store && alu_store;
        push1    = alu_req;
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDRESS_SIZE),
        .DATA_W (WORD_SIZE)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0_en    (push0_en),
        .push0_dest  (push0.dest),
        .push0_data  (push0.data),
        .push1_en    (push1_en),
        .push1_dest  (push1.dest),
        .push1_data  (push1.data),
        .pop         (count != '0),
        .head_dest   (bus.Dest_wb),
        .head_data   (bus.Result_WB),
        .count       (count),
        .entry_dest  (entry_dest),
        .entry_valid (entry_valid)
    );

    assign bus.count       = count;
    assign bus.writeBackEn = (count != '0);

    // The head being written this cycle is still pending: it is only
    // readable from the register file after the edge.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_dest[i] == bus.src1)) hit1 = 1'b1;
            if (entry_valid[i] && (entry_dest[i] == bus.src2)) hit2 = 1'b1;
        end
        if (bus.mem_valid && (bus.mem_dest == bus.src1)) hit1 = 1'b1;
        if (bus.alu_valid && (bus.alu_dest == bus.src1)) hit1 = 1'b1;
        if (bus.mem_valid && (bus.mem_dest == bus.src2)) hit2 = 1'b1;
        if (bus.alu_valid && (bus.alu_dest == bus.src2)) hit2 = 1'b1;
    end

    assign bus.hazard1 = (bus.src1 != ZERO_REG) && hit1;
    assign bus.hazard2 = (bus.src2 != ZERO_REG) && hit2;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue (DEPTH=4, 32-bit data, 4-bit dest).
module tb_wb_write_queue;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [35:0] exp_q[$];

    wb_write_queue_if #(.WORD_SIZE(32), .ADDRESS_SIZE(4), .DEPTH(4)) bus ();

    wb_write_queue #(.WORD_SIZE(32), .ADDRESS_SIZE(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [3:0] md, input logic [31:0] mdat,
                         input logic av, input logic [3:0] ad, input logic [31:0] adat);
        bus.mem_valid = mv;
        bus.mem_dest  = md;
        bus.mem_data  = mdat;
        bus.alu_valid = av;
        bus.alu_dest  = ad;
        bus.alu_data  = adat;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic expect_wb(input logic [3:0] d, input logic [31:0] v);
        exp_q.push_back({d, v});
    endtask

    // Write scoreboard: an entry on the outputs at a negedge (outside reset)
    // is committed by the register file at the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("count_le_depth", 64'(bus.count <= 3'd4), 64'd1);
            if (bus.writeBackEn) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", {28'd0, bus.Dest_wb, bus.Result_WB}, 64'd0);
                end else begin
                    check("wb_entry", {28'd0, bus.Dest_wb, bus.Result_WB}, {28'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        bus.src1 = 4'd0;
        bus.src2 = 4'd0;

        // reset then single push
        tick();
        tick();
        check("rst_count", bus.count, 0);
        check("rst_wbe", bus.writeBackEn, 0);
        check("rst_dest", bus.Dest_wb, 0);
        check("rst_result", bus.Result_WB, 0);
        check("rst_mem_ready", bus.mem_ready, 0);
        check("rst_alu_ready", bus.alu_ready, 0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h11);
        #1;
        check("single_alu_ready", bus.alu_ready, 1);
        check("single_wbe_before", bus.writeBackEn, 0);
        expect_wb(4'd3, 32'h11);
        tick();
        idle();
        check("single_wbe", bus.writeBackEn, 1);
        check("single_dest", bus.Dest_wb, 3);
        check("single_result", bus.Result_WB, 32'h11);
        check("single_count", bus.count, 1);
        tick();
        check("single_wbe_after", bus.writeBackEn, 0);
        check("single_count_after", bus.count, 0);
        check("empty_dest", bus.Dest_wb, 0);
        check("empty_result", bus.Result_WB, 0);

        // dual push ordering
        drive(1'b1, 4'd5, 32'hAA, 1'b1, 4'd6, 32'hBB);
        #1;
        check("dual_mem_ready", bus.mem_ready, 1);
        check("dual_alu_ready", bus.alu_ready, 1);
        expect_wb(4'd5, 32'hAA);
        expect_wb(4'd6, 32'hBB);
        tick();
        idle();
        check("dual_count2", bus.count, 2);
        check("dual_dest_first", bus.Dest_wb, 5);
        check("dual_result_first", bus.Result_WB, 32'hAA);
        tick();
        check("dual_count1", bus.count, 1);
        check("dual_dest_second", bus.Dest_wb, 6);
        check("dual_result_second", bus.Result_WB, 32'hBB);
        tick();
        check("dual_count0", bus.count, 0);

        // backpressure while draining
        drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102);
        expect_wb(4'd1, 32'h101);
        expect_wb(4'd2, 32'h102);
        tick();
        check("bp_count2", bus.count, 2);
        drive(1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104);
        #1;
        check("bp_c2_mem_ready", bus.mem_ready, 1);
        check("bp_c2_alu_ready", bus.alu_ready, 1);
        expect_wb(4'd3, 32'h103);
        expect_wb(4'd4, 32'h104);
        tick();
        check("bp_count3", bus.count, 3);
        drive(1'b1, 4'd5, 32'h105, 1'b1, 4'd6, 32'h106);
        #1;
        check("bp_c3_mem_ready", bus.mem_ready, 1);
        check("bp_c3_alu_ready", bus.alu_ready, 0);
        expect_wb(4'd5, 32'h105);
        tick();
        check("bp_count3_again", bus.count, 3);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h107);
        #1;
        check("bp_alu_only_ready", bus.alu_ready, 1);
        expect_wb(4'd7, 32'h107);
        tick();
        idle();
        check("bp_count_hold", bus.count, 3);
        tick();
        tick();
        tick();
        check("bp_drained", bus.count, 0);

        // dest 0 is accepted but never stored
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'hFF);
        #1;
        check("d0_alu_ready", bus.alu_ready, 1);
        tick();
        idle();
        check("d0_count", bus.count, 0);
        check("d0_wbe", bus.writeBackEn, 0);
        tick();
        check("d0_wbe_later", bus.writeBackEn, 0);

        // hazards
        drive(1'b1, 4'd9, 32'h99, 1'b1, 4'd7, 32'h77);
        expect_wb(4'd9, 32'h99);
        expect_wb(4'd7, 32'h77);
        tick();
        idle();
        bus.src1 = 4'd7;
        bus.src2 = 4'd8;
        #1;
        check("hz_q7_src1", bus.hazard1, 1);
        check("hz_q7_src2_8", bus.hazard2, 0);
        bus.src1 = 4'd0;
        #1;
        check("hz_src1_zero", bus.hazard1, 0);
        bus.src1 = 4'd7;
        tick();
        check("hz_head_dest7", bus.Dest_wb, 7);
        check("hz_during_write", bus.hazard1, 1);
        tick();
        check("hz_cleared", bus.hazard1, 0);
        bus.mem_valid = 1'b1;
        bus.mem_dest  = 4'd8;
        #1;
        check("hz_mem_input", bus.hazard2, 1);
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_dest  = 4'd8;
        #1;
        check("hz_alu_input", bus.hazard2, 1);
        idle();
        #1;
        check("hz_idle", bus.hazard2, 0);
        bus.src1 = 4'd0;
        bus.src2 = 4'd0;

        // reset mid-operation: 11, 12, 13 are discarded
        drive(1'b1, 4'd10, 32'hA0, 1'b1, 4'd11, 32'hB0);
        expect_wb(4'd10, 32'hA0);
        tick();
        drive(1'b1, 4'd12, 32'hC0, 1'b1, 4'd13, 32'hD0);
        tick();
        idle();
        check("mid_count3", bus.count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_wbe", bus.writeBackEn, 0);
        tick();
        tick();
        check("mid_rst_wbe_later", bus.writeBackEn, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Producer side of the register file's single write-back port. Accepts write requests from two pipeline sources: the memory/load path and the ALU path.
- Buffers the requests in a small in-order FIFO and drains one entry per cycle onto Dest_wb / Result_WB / writeBackEn.
- Reports read-after-write hazards on the decode read addresses src1/src2 while a write to that register is still pending.

Parameters:
WORD_SIZE, 32, data width of one register
ADDRESS_SIZE, 4, register address width (16 registers, R0 hard-wired zero)
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
mem_valid  input  1  load-result write request
mem_dest  input  ADDRESS_SIZE  load destination register
mem_data  input  WORD_SIZE  load data
mem_ready  output  1  mem request accepted this cycle when mem_valid is also high
alu_valid  input  1  ALU-result write request
alu_dest  input  ADDRESS_SIZE  ALU destination register
alu_data  input  WORD_SIZE  ALU result
alu_ready  output  1  ALU request accepted this cycle when alu_valid is also high
src1  input  ADDRESS_SIZE  decode read address 1
src2  input  ADDRESS_SIZE  decode read address 2
hazard1  output  1  src1 has a pending write
hazard2  output  1  src2 has a pending write
writeBackEn  output  1  write strobe to the register file
Dest_wb  output  ADDRESS_SIZE  write address
Result_WB  output  WORD_SIZE  write data
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (sync, active-high, at posedge): count=0, read/write pointers=0, writeBackEn=0, Dest_wb=0, Result_WB=0.
  - While rst is high, mem_ready=alu_ready=0.
  - Entries queued before a reset are discarded and never written. Storage contents need not be cleared.
- Ready logic uses the current count only. A pop in the same cycle does not free space for that cycle's accept. Let free = DEPTH - count.
  - mem_ready = (free >= 1).
  - alu_ready = mem_valid ? (free >= 2) : (free >= 1).
- Accept and ordering:
  - A request is accepted when valid && ready.
  - Up to two pushes per cycle are allowed.
  - On a simultaneous accept, the mem entry is enqueued first because it is the older instruction, then the ALU entry.
- Dest 0:
  - A request with dest==0 is accepted under normal handshake rules but is not stored.
  - It does not change count and never produces a write.
- Drain:
  - writeBackEn = (count != 0).
  - Dest_wb and Result_WB come directly from the head entry's flops. When the queue is empty they hold 0.
  - At every posedge with count != 0, the head is popped. The register file commits it on the same edge.
- Latency: a request accepted at edge N into an empty queue appears on the outputs after edge N and is written at edge N+1. There is no combinational input-to-output bypass.
- Count update: count_next = count + pushes_stored - pop, with pushes_stored in 0..2 and pop in 0..1.
  - Pointers wrap modulo DEPTH.
  - count can never exceed DEPTH.
- Hazards (combinational):
  - hazard1 = (src1 != 0) && (any stored entry has dest==src1, || mem_valid && mem_dest==src1, || alu_valid && alu_dest==src1).
  - hazard2 is the same check for src2.
  - The head entry being written this cycle still counts as pending, because it is not readable until after the edge.
- Duplicate destinations are legal. Entries drain in order, so the youngest entry's value lands last.

Decomposition:
- Shared package holds:
  - the WORD_SIZE and ADDRESS_SIZE defaults;
  - the ZERO_REG constant (0);
  - the wb_entry struct {dest, data}.
- One sub-module, wb_fifo: a generic DEPTH-entry FIFO with a 2-push / 1-pop port and an occupancy output. It exposes per-entry dest and valid for the hazard compare.
- The top-level block keeps the ready logic, the dest-0 filter and the hazard compare.

Test Plan:
- Reset then single push: assert rst 2 cycles, then alu_valid, dest=3, data=0x11 for one cycle → next cycle writeBackEn=1, Dest_wb=3, Result_WB=0x11; one cycle later writeBackEn=0 and count=0.
- Dual push ordering: mem (dest 5, 0xAA) and ALU (dest 6, 0xBB) in the same cycle on an empty queue → writes 5/0xAA then 6/0xBB on consecutive cycles; count goes 2→1→0.
- Full and backpressure: push continuously while draining, with DEPTH=4.
  - At count=4: mem_ready=alu_ready=0.
  - At count=3 with both valid: mem_ready=1, alu_ready=0.
  - No entry is lost or reordered.
- Dest-0 drop: alu_valid with dest=0, data=0xFF → accepted (alu_ready=1), count stays 0, writeBackEn never asserts.
- Hazards:
  - With dest 7 queued: src1=7 gives hazard1=1, src2=8 gives hazard2=0, src1=0 gives hazard1=0.
  - hazard1 stays 1 through the cycle in which dest 7 is on the outputs, and clears after that edge.
- Reset mid-operation: 3 entries queued, assert rst for one cycle → count=0 and writeBackEn=0 next cycle; no further writes appear.
